// File: rtl/median_window_gen.sv
// median_window_gen
// Streaming 3x3 window generator feeding the pipelined median stage.
// Takes a raster-order 8-bit pixel stream, keeps the two previous lines in
// line buffers and presents every fully interior 3x3 neighbourhood.
//
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - asynchronous active-high reset
//   in_valid   - in_pixel valid this cycle (always accepted)
//   in_sof     - with in_valid: this beat is pixel (0,0) of a new frame
//   in_pixel   - 8-bit pixel, raster order
//   p0..p8     - window: top p6 p7 p8 / middle p5 p0 p1 / bottom p4 p3 p2
//   out_valid  - one-cycle pulse, p0..p8 hold an interior window
//   frame_done - one-cycle pulse after the last pixel of a frame
module median_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pixel,
  output logic [7:0] p0,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] p4,
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8,
  output logic       out_valid,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic          last_col;
  logic          last_row;

  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];
  logic [7:0] lb1_rd;
  logic [7:0] lb2_rd;

  // in_sof forces the current beat to (0,0) whatever the counters say.
  always_comb begin
    eff_col  = in_sof ? '0 : col;
    eff_row  = in_sof ? '0 : row;
    last_col = (eff_col == CW'(IMG_WIDTH - 1));
    last_row = (eff_row == RW'(IMG_HEIGHT - 1));
    lb1_rd   = lb1[eff_col];
    lb2_rd   = lb2[eff_col];
  end

  // Line buffers: read-before-write, LB1 cascades into LB2. Not reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2[eff_col] <= lb1_rd;
      lb1[eff_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      p0 <= '0; p1 <= '0; p2 <= '0;
      p3 <= '0; p4 <= '0; p5 <= '0;
      p6 <= '0; p7 <= '0; p8 <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end
        // Columns shift left; new right column enters from the buffers.
        p6 <= p7; p7 <= p8; p8 <= lb2_rd;
        p5 <= p0; p0 <= p1; p1 <= lb1_rd;
        p4 <= p3; p3 <= p2; p2 <= in_pixel;
        // Row/col gate also masks stale columns and previous-frame buffer data.
        out_valid  <= (eff_row >= RW'(2)) && (eff_col >= CW'(2));
        frame_done <= last_row && last_col;
      end
    end
  end

endmodule

// File: doc/median_window_gen.md
# median_window_gen

Streaming 3x3 window generator that produces the nine-pixel kernel consumed by the pipelined median calculator. It accepts a raster-order 8-bit pixel stream, buffers the two previous image lines, and presents each fully interior 3x3 neighbourhood on p0–p8 using the codebase kernel naming. It sits between the pixel source and the median stage.

## Interface

**Parameters**
- IMG_WIDTH, 640: pixels per line, ≥ 3.
- IMG_HEIGHT, 480: lines per frame, ≥ 3.

**Ports**
- clk  input  1: clock; all logic on posedge.
- rst  input  1: asynchronous, active-high reset.
- in_valid  input  1: in_pixel is valid this cycle; every valid beat is accepted (no backpressure).
- in_sof  input  1: qualified by in_valid; the beat is pixel (row 0, col 0) of a new frame.
- in_pixel  input  8: pixel data, raster order.
- p0..p8  output  8 each: window pixels, in this layout:
  - top row: p6 | p7 | p8
  - middle row: p5 | p0 | p1
  - bottom row: p4 | p3 | p2
  - p0 is the centre, the top row is the oldest line, and the left column is the oldest column.
- out_valid  output  1: p0..p8 hold a complete interior window; one-cycle pulse per window.
- frame_done  output  1: one-cycle pulse when the last pixel of a frame is accepted.

## Operation

**Counters**
- col counter: $clog2(IMG_WIDTH) bits. row counter: $clog2(IMG_HEIGHT) bits.
- Both advance only on accepted beats.
- col wraps from IMG_WIDTH-1 to 0 and increments row.
- row wraps from IMG_HEIGHT-1 to 0, so back-to-back frames need no in_sof.
- A beat with in_sof=1 is taken as (0,0) regardless of counter state; counters then continue from (0,1).

**Line buffers**
- Two IMG_WIDTH x 8 memories, addressed by col.
- LB1 holds row r-1; LB2 holds row r-2.
- On an accepted beat at column c: read LB1[c] and LB2[c] (read-before-write), then write LB2[c] ← old LB1[c] and LB1[c] ← in_pixel.
- Memory contents are not reset.

**Window shift register**
- 3x3 registers. On each accepted beat, every row shifts left by one column.
- The new right column is {top = old LB2[c], middle = old LB1[c], bottom = in_pixel}.
- The window registers drive p0..p8 directly.

**Valid generation**
- For an accepted beat at (r,c) with r ≥ 2 and c ≥ 2, set out_valid=1 on the next cycle. The window is then centred on pixel (r-1, c-1).
- Border pixels produce no window.
- Each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) pulses.
- The shift register is not cleared at line start. Stale columns are never flagged valid, because the c ≥ 2 gate covers them.

**frame_done**
- Pulses on the cycle after the beat at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
- It coincides with the frame's final out_valid.

## Timing

**Reset**
- Values: out_valid=0, frame_done=0, p0..p8=0, col=0, row=0.
- Takes effect immediately (asynchronous).
- After reset, the first accepted beat is treated as (0,0) even without in_sof.

**Latency**
- One cycle from the accepting edge to out_valid / p0..p8.
- p0..p8 hold their value while in_valid=0. out_valid is 0 on idle cycles.

**Gaps and throughput**
- in_valid may deassert at any cycle, including mid-line. The output windows are identical to the gapless case, only spread in time.
- Full rate is one pixel per clock, sustained indefinitely.

**Boundary cases**
- in_sof mid-frame: the frame restarts at (0,0). No window is produced until the new frame reaches row 2, col 2. The previous frame's line-buffer data is never reported as valid.
- Reset mid-frame: the partial frame is discarded. Behaviour is identical to the boundary-case above.
- in_sof at the natural wrap point (counter already at (0,0)): no effect beyond the normal wrap.
- in_sof with in_valid=0: ignored.

## Test plan

- **Basic 4x4 window.** IMG_WIDTH=4, IMG_HEIGHT=4; pixel = 4r+c, gapless, in_sof on the first beat.
  - Expect exactly 4 out_valid pulses.
  - Window 1: p6=0, p7=1, p8=2, p5=4, p0=5, p1=6, p4=8, p3=9, p2=10.
  - Window 2: p0=6 (p2=11).
  - Windows 3 and 4: p0=9 and p0=10.
  - frame_done coincides with window 4.
- **Gapped input.** Same frame with random 0–3 idle cycles between beats.
  - Identical 4 windows in the same order.
  - out_valid=0 on every idle cycle; each pulse arrives 1 cycle after the beat that completes its window.
- **Back-to-back frames.** Two 4x4 frames with no in_sof on the second (second frame pixel = 4r+c+100).
  - Second frame gives 4 windows, first with p0=105 and p6=100.
  - No window mixes data from both frames.
  - frame_done pulses twice.
- **in_sof restart.** 4x4 frame with in_sof reasserted at beat (2,1), followed by a full frame.
  - Zero windows from the aborted frame.
  - The new frame's windows match the basic 4x4 case (values offset accordingly).
- **Reset mid-frame.** Assert rst for 2 cycles at beat (2,2), then send a full frame without in_sof.
  - out_valid, frame_done and p0..p8 read 0 during and after reset.
  - Exactly 4 correct windows follow.
- **Full-size soak.** Defaults (640x480), random pixels, random gaps.
  - 638*478 = 304964 pulses.
  - p0..p8 match a software 3x3 extraction for every window.
